// File: rtl/laplace_multi_streamer.sv
// Streams NUM_CH packed-ASCII strings for one table line over a valid/ready handshake.
// Optional beacon mode (line repeats while start is held) is enabled by LAPLACE_STREAMER_LOOP_EN.
module laplace_multi_streamer #(
  parameter int                NUM_CH   = 2,
  parameter int                LINE_W   = 6,
  parameter int                ADDR_W   = 10,
  parameter int                LEN_W    = 10,
  parameter int                CHAR_W   = 8,
  parameter logic [CHAR_W-1:0] PAD_CHAR = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LINE_W-1:0]             line,
  output logic [LINE_W-1:0]             ptr_line,
  input  logic [NUM_CH*(ADDR_W+LEN_W)-1:0] ptr_data,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [2*CHAR_W-1:0]           mem_dout,
  output logic [NUM_CH*CHAR_W-1:0]      out_char,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [LEN_W-1:0]              chars_remaining,
  output logic [2:0]                    which_state
);

  localparam int ENT_W = ADDR_W + LEN_W;
  localparam int CNT_W = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    LOAD    = 3'd2,
    FETCH   = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [LINE_W-1:0]   line_reg;
  logic [ADDR_W-1:0]   base_reg [NUM_CH];
  logic [LEN_W-1:0]    len_reg  [NUM_CH];
  logic [CHAR_W-1:0]   char_reg [NUM_CH];
  logic [ADDR_W-1:0]   base_in  [NUM_CH];
  logic [LEN_W-1:0]    len_in   [NUM_CH];
  logic [LEN_W-1:0]    max_len_reg, max_in;
  logic [LEN_W-1:0]    k_reg, k_inc;
  logic [CNT_W-1:0]    cnt_reg;
  logic                loop_exit;
`ifdef LAPLACE_STREAMER_LOOP_EN
  logic                looping_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign base_in[gi] = ptr_data[gi*ENT_W+LEN_W +: ADDR_W];
      assign len_in[gi]  = ptr_data[gi*ENT_W +: LEN_W];
      assign out_char[gi*CHAR_W +: CHAR_W] = char_reg[gi];
    end
  endgenerate

  always_comb begin
    max_in = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (len_in[c] > max_in) max_in = len_in[c];
  end

  assign k_inc = k_reg + LEN_W'(1);

`ifdef LAPLACE_STREAMER_LOOP_EN
  // Once repeating, dropping start finishes the current beat instead of the whole line.
  assign loop_exit = looping_reg && !start;
`else
  assign loop_exit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOOKUP;
      LOOKUP:  state_next = LOAD;
      LOAD:    state_next = (max_in == '0) ? DONE : FETCH;
      FETCH:   if (cnt_reg == CNT_W'(NUM_CH)) state_next = PRESENT;
      PRESENT: if (out_ready) state_next = (k_inc == max_len_reg || loop_exit) ? DONE : FETCH;
      DONE: begin
`ifdef LAPLACE_STREAMER_LOOP_EN
        if (start && max_len_reg != '0) state_next = FETCH;
        else if (!start)                state_next = IDLE;
`else
        if (!start) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Address for channel cnt is issued while the previous channel's word arrives.
  always_comb begin
    mem_addr = '0;
    if (state_reg == FETCH)
      for (int c = 0; c < NUM_CH; c++)
        if (cnt_reg == CNT_W'(c)) mem_addr = base_reg[c] + ADDR_W'(k_reg >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      line_reg    <= '0;
      max_len_reg <= '0;
      k_reg       <= '0;
      cnt_reg     <= '0;
`ifdef LAPLACE_STREAMER_LOOP_EN
      looping_reg <= 1'b0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
        base_reg[c] <= '0;
        len_reg[c]  <= '0;
        char_reg[c] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) line_reg <= line;
`ifdef LAPLACE_STREAMER_LOOP_EN
          looping_reg <= 1'b0;
`endif
        end
        LOAD: begin
          for (int c = 0; c < NUM_CH; c++) begin
            base_reg[c] <= base_in[c];
            len_reg[c]  <= len_in[c];
          end
          max_len_reg <= max_in;
          k_reg       <= '0;
          cnt_reg     <= '0;
        end
        FETCH: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          for (int c = 0; c < NUM_CH; c++)
            if (cnt_reg == CNT_W'(c + 1))
              char_reg[c] <= (k_reg >= len_reg[c]) ? PAD_CHAR :
                             (k_reg[0] ? mem_dout[CHAR_W-1:0] : mem_dout[2*CHAR_W-1:CHAR_W]);
        end
        PRESENT: begin
          cnt_reg <= '0;
          if (out_ready) k_reg <= k_inc;
        end
        DONE: begin
`ifdef LAPLACE_STREAMER_LOOP_EN
          if (start && max_len_reg != '0) begin
            k_reg       <= '0;
            cnt_reg     <= '0;
            looping_reg <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign ptr_line        = line_reg;
  assign out_valid       = (state_reg == PRESENT);
  assign busy            = (state_reg != IDLE);
  assign which_state     = state_reg;
  assign chars_remaining = (state_reg == FETCH || state_reg == PRESENT) ? (max_len_reg - k_reg) : '0;

endmodule
